alu_issue_ctrl: RTL and testbench

- Issue/sequencing controller that drives the combinational ALU (opcode, operands, 5-bit immediate, shift/carry-in) and consumes its result and Zero/Parity/Odd flags.
- Accepts 9-bit instructions over a valid/ready handshake and sequences: register read, ALU execute, register writeback.
- Holds architectural flags and a retired-instruction counter.
- Sits between fetch and the 4-entry register file, on the opposite end of the ALU's OP/operand/flag interface.

---
 rtl/alu_issue_ctrl_pkg.sv | 38 +++
 rtl/alu_issue_ctrl_if.sv | 61 ++++++
 rtl/alu_issue_ctrl_decode.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode and state encodings,
// instruction field positions and datapath sizes.
package alu_issue_ctrl_pkg;

  localparam int OPS     = 4;
  localparam int INSTR_W = 9;
  localparam int IMM_W   = 5;

  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 5;
  localparam int IMM_MSB = 4;
  localparam int IMM_LSB = 0;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  localparam logic [1:0] R0 = 2'd0;

  typedef enum logic [OPS-1:0] {
    OP_ADD = 4'd0,
    OP_LSL = 4'd1,
    OP_LSR = 4'd2,
    OP_XOR = 4'd3,
    OP_SNE = 4'd4,
    OP_SEQ = 4'd5,
    OP_MSK = 4'd6
  } op_mne_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EX,
    WB,
    ERR
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of fetch handshake, register file and ALU signals around the issue
// controller; master is the controller side, slave is its environment.
interface alu_issue_ctrl_if
  import alu_issue_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
);

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               abort;

  logic [1:0]         reg_addr_a;
  logic [1:0]         reg_addr_b;
  logic [W-1:0]       reg_data_a;
  logic [W-1:0]       reg_data_b;

  logic [OPS-1:0]     alu_op;
  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [IMM_W-1:0]   alu_imm;
  logic               alu_sc;
  logic [W-1:0]       alu_out;
  logic               alu_zero;
  logic               alu_parity;
  logic               alu_odd;

  logic               reg_wr_en;
  logic [1:0]         reg_wr_addr;
  logic [W-1:0]       reg_wr_data;

  logic               done;
  logic               illegal_op;
  logic               zero_flag;
  logic               parity_flag;
  logic               odd_flag;
  logic [CW-1:0]      retire_count;

  modport master (
    input  instr_valid, instr, abort,
    input  reg_data_a, reg_data_b,
    input  alu_out, alu_zero, alu_parity, alu_odd,
    output instr_ready, reg_addr_a, reg_addr_b,
    output alu_op, alu_a, alu_b, alu_imm, alu_sc,
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    output done, illegal_op, zero_flag, parity_flag, odd_flag, retire_count
  );

  modport slave (
    output instr_valid, instr, abort,
    output reg_data_a, reg_data_b,
    output alu_out, alu_zero, alu_parity, alu_odd,
    input  instr_ready, reg_addr_a, reg_addr_b,
    input  alu_op, alu_a, alu_b, alu_imm, alu_sc,
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    input  done, illegal_op, zero_flag, parity_flag, odd_flag, retire_count
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decoder: opcode legality, operand class and the
// register/immediate fields of a 9-bit instruction.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OPS-1:0]     op,
  output logic               legal,
  output logic               reg_class,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [IMM_W-1:0]   imm
);

  always_comb begin
    op        = instr[OP_MSB:OP_LSB];
    rd        = instr[RD_MSB:RD_LSB];
    rs        = instr[RS_MSB:RS_LSB];
    imm       = instr[IMM_MSB:IMM_LSB];
    legal     = 1'b0;
    reg_class = 1'b0;
    case (op)
      OP_ADD, OP_LSL, OP_LSR, OP_SNE, OP_SEQ: legal = 1'b1;
      OP_XOR, OP_MSK: begin
        legal     = 1'b1;
        reg_class = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction at a time and steps it through
// register read, ALU execute and writeback, keeping flags and a retire count.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
)(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.master bus
);

  logic [OPS-1:0]   dec_op;
  logic             dec_legal;
  logic             dec_reg_class;
  logic [1:0]       dec_rd;
  logic [1:0]       dec_rs;
  logic [IMM_W-1:0] dec_imm;

  alu_op_decode u_decode (
    .instr     (bus.instr),
    .op        (dec_op),
    .legal     (dec_legal),
    .reg_class (dec_reg_class),
    .rd        (dec_rd),
    .rs        (dec_rs),
    .imm       (dec_imm)
  );

  state_e           state;
  logic             instr_ready_q;
  logic [OPS-1:0]   op_q;
  logic             reg_class_q;
  logic [1:0]       dest_q;
  logic [IMM_W-1:0] imm_q;
  logic [1:0]       reg_addr_a_q;
  logic [1:0]       reg_addr_b_q;
  logic [OPS-1:0]   alu_op_q;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [IMM_W-1:0] alu_imm_q;
  logic [W-1:0]     res_q;
  logic             res_zero_q;
  logic             res_parity_q;
  logic             res_odd_q;
  logic             wr_en_q;
  logic [1:0]       wr_addr_q;
  logic             done_q;
  logic             illegal_q;
  logic             zero_q;
  logic             parity_q;
  logic             odd_q;
  logic [CW-1:0]    count_q;

  // Abort in any busy state drops straight back to IDLE; the writeback-side
  // effects are only committed on the WB exit edge so a late abort can cancel them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      instr_ready_q <= 1'b1;
      op_q          <= '0;
      reg_class_q   <= 1'b0;
      dest_q        <= R0;
      imm_q         <= '0;
      reg_addr_a_q  <= R0;
      reg_addr_b_q  <= R0;
      alu_op_q      <= OP_ADD;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_imm_q     <= '0;
      res_q         <= '0;
      res_zero_q    <= 1'b0;
      res_parity_q  <= 1'b0;
      res_odd_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= R0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      zero_q        <= 1'b0;
      parity_q      <= 1'b0;
      odd_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid && instr_ready_q) begin
            instr_ready_q <= 1'b0;
            op_q          <= dec_op;
            reg_class_q   <= dec_reg_class;
            dest_q        <= dec_reg_class ? dec_rd : R0;
            imm_q         <= dec_imm;
            reg_addr_a_q  <= dec_reg_class ? dec_rd : R0;
            reg_addr_b_q  <= dec_reg_class ? dec_rs : R0;
            if (dec_legal) begin
              state <= RD;
            end else begin
              state     <= ERR;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (bus.abort) begin
            state         <= IDLE;
            instr_ready_q <= 1'b1;
          end else begin
            alu_op_q  <= op_q;
            alu_a_q   <= bus.reg_data_a;
            alu_b_q   <= reg_class_q ? bus.reg_data_b : '0;
            alu_imm_q <= reg_class_q ? '0 : imm_q;
            state     <= EX;
          end
        end
        EX: begin
          if (bus.abort) begin
            state         <= IDLE;
            instr_ready_q <= 1'b1;
          end else begin
            res_q        <= bus.alu_out;
            res_zero_q   <= bus.alu_zero;
            res_parity_q <= bus.alu_parity;
            res_odd_q    <= bus.alu_odd;
            wr_en_q      <= 1'b1;
            wr_addr_q    <= dest_q;
            done_q       <= 1'b1;
            state        <= WB;
          end
        end
        WB: begin
          if (!bus.abort) begin
            zero_q   <= res_zero_q;
            parity_q <= res_parity_q;
            odd_q    <= res_odd_q;
            count_q  <= count_q + 1'b1;
          end
          state         <= IDLE;
          instr_ready_q <= 1'b1;
        end
        ERR: begin
          state         <= IDLE;
          instr_ready_q <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          instr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_ready  = instr_ready_q;
  assign bus.reg_addr_a   = reg_addr_a_q;
  assign bus.reg_addr_b   = reg_addr_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_imm      = alu_imm_q;
  assign bus.alu_sc       = 1'b0;
  assign bus.reg_wr_en    = wr_en_q & ~bus.abort;
  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.reg_wr_data  = res_q;
  assign bus.done         = done_q & ~bus.abort;
  assign bus.illegal_op   = illegal_q;
  assign bus.zero_flag    = zero_q;
  assign bus.parity_flag  = parity_q;
  assign bus.odd_flag     = odd_q;
  assign bus.retire_count = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file and ALU.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.W(8), .CW(8)) bus();

  alu_issue_ctrl #(.W(8), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] rf [4];
  logic       pre_en = 1'b0;
  logic [1:0] pre_addr = 2'd0;
  logic [7:0] pre_data = 8'd0;

  assign bus.reg_data_a = rf[bus.reg_addr_a];
  assign bus.reg_data_b = rf[bus.reg_addr_b];

  always @(posedge clk) begin
    if (bus.reg_wr_en) rf[bus.reg_wr_addr] <= bus.reg_wr_data;
    else if (pre_en) rf[pre_addr] <= pre_data;
  end

  // Behavioural ALU model on the far side of the operand/flag interface
  always_comb begin
    logic [7:0] r;
    r = bus.alu_a;
    case (bus.alu_op)
      OP_ADD: r = bus.alu_a + {3'b000, bus.alu_imm};
      OP_LSL: r = bus.alu_a << bus.alu_imm[2:0];
      OP_LSR: r = bus.alu_a >> bus.alu_imm[2:0];
      OP_XOR: r = bus.alu_a ^ bus.alu_b;
      OP_SNE: r = {7'd0, bus.alu_a != {3'b000, bus.alu_imm}};
      OP_SEQ: r = {7'd0, bus.alu_a == {3'b000, bus.alu_imm}};
      OP_MSK: r = bus.alu_a & bus.alu_b;
      default: r = bus.alu_a;
    endcase
    bus.alu_out    = r;
    bus.alu_zero   = (r == 8'd0);
    bus.alu_parity = ^r;
    bus.alu_odd    = r[0];
  end

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run_instr(input logic [8:0] i, output bit timed_out);
    int n;
    @(negedge clk);
    bus.instr       = i;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 8);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b want 1", bus.instr_ready); end
    tests++; if (bus.reg_wr_en !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_strobes: wr_en %b done %b want 0 0", bus.reg_wr_en, bus.done); end
    tests++; if ({bus.illegal_op, bus.zero_flag, bus.parity_flag, bus.odd_flag} !== 4'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b want 0000", {bus.illegal_op, bus.zero_flag, bus.parity_flag, bus.odd_flag}); end
    tests++; if (bus.retire_count !== 8'd0 || bus.alu_op !== 4'd0 || bus.alu_imm !== 5'd0) begin fails++; $display("[TB] FAIL reset_regs: count %0d op %0d imm %0d want 0 0 0", bus.retire_count, bus.alu_op, bus.alu_imm); end
    rst_n = 1'b1;
    preload(2'd0, 8'h11);
    @(negedge clk);
    bus.instr       = 9'b0000_00001;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    tests++; if (bus.alu_a !== 8'h11) begin fails++; $display("[TB] FAIL midex_alu_a: got %h want 11", bus.alu_a); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.instr_ready !== 1'b1 || bus.reg_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL midex_reset: ready %b wr_en %b want 1 0", bus.instr_ready, bus.reg_wr_en); end
    tests++; if (bus.retire_count !== 8'd0 || bus.alu_a !== 8'd0) begin fails++; $display("[TB] FAIL midex_regs: count %0d alu_a %h want 0 00", bus.retire_count, bus.alu_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1 || rf[0] !== 8'h11) begin fails++; $display("[TB] FAIL midex_after: done %b ready %b r0 %h want 0 1 11", bus.done, bus.instr_ready, rf[0]); end
  endtask

  task automatic test_add();
    preload(2'd0, 8'h05);
    @(negedge clk);
    bus.instr       = 9'b0000_00011;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    tests++; if (bus.reg_addr_a !== 2'd0 || bus.instr_ready !== 1'b0) begin fails++; $display("[TB] FAIL add_rd: addr_a %0d ready %b want 0 0", bus.reg_addr_a, bus.instr_ready); end
    @(negedge clk);
    tests++; if (bus.alu_op !== 4'd0 || bus.alu_imm !== 5'd3 || bus.alu_a !== 8'h05 || bus.alu_b !== 8'h00) begin fails++; $display("[TB] FAIL add_ex: op %0d imm %0d a %h b %h want 0 3 05 00", bus.alu_op, bus.alu_imm, bus.alu_a, bus.alu_b); end
    @(negedge clk);
    tests++; if (bus.reg_wr_en !== 1'b1 || bus.reg_wr_addr !== 2'd0 || bus.reg_wr_data !== 8'h08 || bus.done !== 1'b1) begin fails++; $display("[TB] FAIL add_wb: en %b addr %0d data %h done %b want 1 0 08 1", bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data, bus.done); end
    @(negedge clk);
    tests++; if ({bus.zero_flag, bus.parity_flag, bus.odd_flag} !== 3'b010 || bus.retire_count !== 8'd1) begin fails++; $display("[TB] FAIL add_flags: zpo %b count %0d want 010 1", {bus.zero_flag, bus.parity_flag, bus.odd_flag}, bus.retire_count); end
    tests++; if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || rf[0] !== 8'h08) begin fails++; $display("[TB] FAIL add_idle: ready %b done %b r0 %h want 1 0 08", bus.instr_ready, bus.done, rf[0]); end
  endtask

  task automatic test_xor();
    preload(2'd2, 8'hA5);
    preload(2'd1, 8'hA5);
    @(negedge clk);
    bus.instr       = 9'b0011_01001;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    tests++; if (bus.reg_addr_a !== 2'd2 || bus.reg_addr_b !== 2'd1) begin fails++; $display("[TB] FAIL xor_rd: addr_a %0d addr_b %0d want 2 1", bus.reg_addr_a, bus.reg_addr_b); end
    @(negedge clk);
    tests++; if (bus.alu_op !== 4'd3 || bus.alu_a !== 8'hA5 || bus.alu_b !== 8'hA5 || bus.alu_imm !== 5'd0) begin fails++; $display("[TB] FAIL xor_ex: op %0d a %h b %h imm %0d want 3 a5 a5 0", bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_imm); end
    @(negedge clk);
    tests++; if (bus.reg_wr_en !== 1'b1 || bus.reg_wr_addr !== 2'd2 || bus.reg_wr_data !== 8'h00) begin fails++; $display("[TB] FAIL xor_wb: en %b addr %0d data %h want 1 2 00", bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data); end
    @(negedge clk);
    tests++; if ({bus.zero_flag, bus.parity_flag, bus.odd_flag} !== 3'b100 || bus.retire_count !== 8'd2 || rf[2] !== 8'h00) begin fails++; $display("[TB] FAIL xor_after: zpo %b count %0d r2 %h want 100 2 00", {bus.zero_flag, bus.parity_flag, bus.odd_flag}, bus.retire_count, rf[2]); end
  endtask

  task automatic test_illegal();
    bit to;
    @(negedge clk);
    bus.instr       = 9'b1111_00000;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    tests++; if (bus.done !== 1'b1 || bus.illegal_op !== 1'b1 || bus.reg_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL ill_err: done %b ill %b wr_en %b want 1 1 0", bus.done, bus.illegal_op, bus.reg_wr_en); end
    @(negedge clk);
    tests++; if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.reg_wr_en !== 1'b0 || bus.retire_count !== 8'd2 || bus.zero_flag !== 1'b1) begin fails++; $display("[TB] FAIL ill_after: ready %b done %b wr_en %b count %0d z %b want 1 0 0 2 1", bus.instr_ready, bus.done, bus.reg_wr_en, bus.retire_count, bus.zero_flag); end
    run_instr(9'b0000_00000, to);
    tests++; if (to) begin fails++; $display("[TB] FAIL ill_next_timeout: done %b want 1 within 8 cycles", bus.done); end
    tests++; if (bus.illegal_op !== 1'b1 || bus.retire_count !== 8'd3 || {bus.zero_flag, bus.parity_flag, bus.odd_flag} !== 3'b010) begin fails++; $display("[TB] FAIL ill_sticky: ill %b count %0d zpo %b want 1 3 010", bus.illegal_op, bus.retire_count, {bus.zero_flag, bus.parity_flag, bus.odd_flag}); end
  endtask

  task automatic test_abort_wb();
    @(negedge clk);
    bus.instr       = 9'b0101_01000;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    tests++; if (bus.reg_wr_en !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("[TB] FAIL abort_wb: wr_en %b done %b want 0 0", bus.reg_wr_en, bus.done); end
    @(negedge clk);
    bus.abort = 1'b0;
    tests++; if (bus.instr_ready !== 1'b1 || bus.retire_count !== 8'd3 || rf[0] !== 8'h08) begin fails++; $display("[TB] FAIL abort_after: ready %b count %0d r0 %h want 1 3 08", bus.instr_ready, bus.retire_count, rf[0]); end
    tests++; if ({bus.zero_flag, bus.parity_flag, bus.odd_flag} !== 3'b010) begin fails++; $display("[TB] FAIL abort_flags: zpo %b want 010", {bus.zero_flag, bus.parity_flag, bus.odd_flag}); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int dones = 0;
    bit to;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (bus.illegal_op !== 1'b0 || bus.retire_count !== 8'd0) begin fails++; $display("[TB] FAIL b2b_reset: ill %b count %0d want 0 0", bus.illegal_op, bus.retire_count); end
    @(negedge clk);
    rst_n = 1'b1;
    preload(2'd0, 8'h00);
    @(negedge clk);
    bus.instr       = 9'b0000_00001;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 1020; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.instr_ready !== 1'((c % 4) == 0)) bad++;
      if (bus.done === 1'b1) dones++;
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);
    tests++; if (bad != 0 || dones != 255) begin fails++; $display("[TB] FAIL b2b_cadence: ready mismatches %0d dones %0d want 0 255", bad, dones); end
    tests++; if (bus.retire_count !== 8'd255 || rf[0] !== 8'hFF) begin fails++; $display("[TB] FAIL b2b_count: count %0d r0 %h want 255 ff", bus.retire_count, rf[0]); end
    run_instr(9'b0000_00001, to);
    tests++; if (to) begin fails++; $display("[TB] FAIL wrap_timeout: done %b want 1 within 8 cycles", bus.done); end
    tests++; if (bus.retire_count !== 8'd0 || bus.zero_flag !== 1'b1 || rf[0] !== 8'h00) begin fails++; $display("[TB] FAIL wrap: count %0d z %b r0 %h want 0 1 00", bus.retire_count, bus.zero_flag, rf[0]); end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.abort       = 1'b0;
    test_reset();
    test_add();
    test_xor();
    test_illegal();
    test_abort_wb();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
